// File: rtl/ddr3_axi_pkg.sv
// Shared types and constants for the DDR3 AXI responder: one-hot FSM states,
// channel field widths and the burst-length helper.
package ddr3_axi_pkg;

    localparam int unsigned ID_W    = 4;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned BEATS_W = LEN_W + 1;
    localparam int unsigned BYTE_W  = 8;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_AW_ACC  = 6'b000010,
        ST_AR_ACC  = 6'b000100,
        ST_W_BURST = 6'b001000,
        ST_R_BURST = 6'b010000,
        ST_GAP     = 6'b100000
    } state_e;

    // Burst control captured at the address handshake
    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [ID_W-1:0]  id;
    } req_ctl_t;

    function automatic logic [BEATS_W-1:0] burst_beats(input logic [LEN_W-1:0] len);
        return BEATS_W'(len) + BEATS_W'(1);
    endfunction

endpackage

// File: rtl/ddr3_axi_resp_if.sv
// Address/data channel bundle between the DDR3 controller (master) and the
// DDR3 IP stand-in (slave).
interface ddr3_axi_resp_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 256
);
    import ddr3_axi_pkg::*;

    localparam int unsigned STRB_W = DATA_W / BYTE_W;

    logic [ADDR_W-1:0] axi_awaddr;
    logic [ID_W-1:0]   axi_awuser_id;
    logic [LEN_W-1:0]  axi_awlen;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [DATA_W-1:0] axi_wdata;
    logic [STRB_W-1:0] axi_wstrb;
    logic              axi_wready;
    logic [ID_W-1:0]   axi_wusero_id;
    logic              axi_wusero_last;
    logic [ADDR_W-1:0] axi_araddr;
    logic [ID_W-1:0]   axi_aruser_id;
    logic [LEN_W-1:0]  axi_arlen;
    logic              axi_arvalid;
    logic              axi_arready;
    logic [DATA_W-1:0] axi_rdata;
    logic [ID_W-1:0]   axi_rid;
    logic              axi_rlast;
    logic              axi_rvalid;

    modport master (
        output axi_awaddr, axi_awuser_id, axi_awlen, axi_awvalid,
        output axi_wdata, axi_wstrb,
        output axi_araddr, axi_aruser_id, axi_arlen, axi_arvalid,
        input  axi_awready, axi_wready, axi_wusero_id, axi_wusero_last,
        input  axi_arready, axi_rdata, axi_rid, axi_rlast, axi_rvalid
    );

    modport slave (
        input  axi_awaddr, axi_awuser_id, axi_awlen, axi_awvalid,
        input  axi_wdata, axi_wstrb,
        input  axi_araddr, axi_aruser_id, axi_arlen, axi_arvalid,
        output axi_awready, axi_wready, axi_wusero_id, axi_wusero_last,
        output axi_arready, axi_rdata, axi_rid, axi_rlast, axi_rvalid
    );

endinterface

// File: rtl/ddr3_resp_ram.sv
// Simple dual-port beat RAM with byte write enables and a registered read port
// that holds its last value while no read is issued.
module ddr3_resp_ram
    import ddr3_axi_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned MEM_AW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [MEM_AW-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [DATA_W/BYTE_W-1:0] wr_strb_i,
    input  logic                     rd_en_i,
    input  logic [MEM_AW-1:0]        rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);
    localparam int unsigned STRB_W = DATA_W / BYTE_W;
    localparam int unsigned DEPTH  = 1 << MEM_AW;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage has no reset so contents survive a controller reset
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb_i[b]) begin
                    mem_q[wr_addr_i][b*BYTE_W +: BYTE_W] <= wr_data_i[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ddr3_axi_resp.sv
// DDR3 IP stand-in: accepts one write or read burst at a time, alternating on
// contention. Optional protocol checker enabled by DDR3_RESP_CHK_EN.
module ddr3_axi_resp
    import ddr3_axi_pkg::*;
#(
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned MEM_AW    = 8,
    parameter int unsigned READY_DLY = 2,
    parameter int unsigned GAP_CYC   = 2
) (
    input  logic            clk_100M,
    input  logic            rst,
    ddr3_axi_resp_if.slave  axi,
    output logic            resp_err
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic               prio_rd_q, prio_rd_d;
    req_ctl_t           ctl_q, ctl_d;
    logic [MEM_AW-1:0]  base_q, base_d;

    logic               awready_q, arready_q, wready_q, wlast_q, rvalid_q, rlast_q;
    logic [ID_W-1:0]    wid_q, rid_q;

    logic               sel_wr, sel_valid, last_beat;
    logic [MEM_AW-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_rdata;
    logic               addr_unused;

    assign sel_valid   = axi.axi_awvalid || axi.axi_arvalid;
    assign sel_wr      = axi.axi_awvalid && (!axi.axi_arvalid || !prio_rd_q);
    assign last_beat   = (BEATS_W'(beat_q) + BEATS_W'(1)) == burst_beats(ctl_q.len);
    assign ram_addr    = base_q + MEM_AW'(beat_q);
    assign addr_unused = ^{axi.axi_awaddr, axi.axi_araddr};

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        prio_rd_d = prio_rd_q;
        ctl_d     = ctl_q;
        base_d    = base_q;
        case (state_q)
            ST_IDLE: begin
                if (!sel_valid) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(READY_DLY)) begin
                    cnt_d  = '0;
                    beat_d = '0;
                    if (sel_wr) begin
                        state_d   = ST_AW_ACC;
                        ctl_d.len = axi.axi_awlen;
                        ctl_d.id  = axi.axi_awuser_id;
                        base_d    = axi.axi_awaddr[MEM_AW+2:3];
                    end else begin
                        state_d   = ST_AR_ACC;
                        ctl_d.len = axi.axi_arlen;
                        ctl_d.id  = axi.axi_aruser_id;
                        base_d    = axi.axi_araddr[MEM_AW+2:3];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_AW_ACC: begin
                state_d   = ST_W_BURST;
                prio_rd_d = !prio_rd_q;
            end
            ST_AR_ACC: begin
                state_d   = ST_R_BURST;
                prio_rd_d = !prio_rd_q;
            end
            ST_W_BURST, ST_R_BURST: begin
                if (last_beat) begin
                    state_d = ST_GAP;
                end else begin
                    beat_d = beat_q + LEN_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; read outputs trail the RAM read by a cycle
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            beat_q    <= '0;
            prio_rd_q <= 1'b0;
            ctl_q     <= '0;
            base_q    <= '0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            wready_q  <= 1'b0;
            wlast_q   <= 1'b0;
            wid_q     <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            prio_rd_q <= prio_rd_d;
            ctl_q     <= ctl_d;
            base_q    <= base_d;
            awready_q <= (state_d == ST_AW_ACC);
            arready_q <= (state_d == ST_AR_ACC);
            wready_q  <= (state_d == ST_W_BURST);
            wlast_q   <= (state_d == ST_W_BURST) &&
                         ((BEATS_W'(beat_d) + BEATS_W'(1)) == burst_beats(ctl_d.len));
            wid_q     <= (state_d == ST_W_BURST) ? ctl_d.id : '0;
            rvalid_q  <= (state_q == ST_R_BURST);
            rlast_q   <= (state_q == ST_R_BURST) && last_beat;
            rid_q     <= (state_q == ST_R_BURST) ? ctl_q.id : '0;
        end
    end

    ddr3_resp_ram #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW)
    ) u_ram (
        .clk       (clk_100M),
        .rst       (rst),
        .wr_en_i   (wready_q),
        .wr_addr_i (ram_addr),
        .wr_data_i (axi.axi_wdata),
        .wr_strb_i (axi.axi_wstrb),
        .rd_en_i   (state_q == ST_R_BURST),
        .rd_addr_i (ram_addr),
        .rd_data_o (ram_rdata)
    );

    assign axi.axi_awready     = awready_q;
    assign axi.axi_arready     = arready_q;
    assign axi.axi_wready      = wready_q;
    assign axi.axi_wusero_last = wlast_q;
    assign axi.axi_wusero_id   = wid_q;
    assign axi.axi_rvalid      = rvalid_q;
    assign axi.axi_rlast       = rlast_q;
    assign axi.axi_rid         = rid_q;
    assign axi.axi_rdata       = ram_rdata;

`ifdef DDR3_RESP_CHK_EN
    logic              chk_wr_q;
    logic [ADDR_W-1:0] chk_addr_q;
    logic [LEN_W-1:0]  chk_len_q;
    logic              err_q;
    logic              hold_valid, err_hit;
    logic [ADDR_W-1:0] hold_addr;
    logic [LEN_W-1:0]  hold_len;

    // Request tracked is the one selected when its delay count started
    always_comb begin
        hold_valid = chk_wr_q ? axi.axi_awvalid : axi.axi_arvalid;
        hold_addr  = chk_wr_q ? axi.axi_awaddr  : axi.axi_araddr;
        hold_len   = chk_wr_q ? axi.axi_awlen   : axi.axi_arlen;
        err_hit    = 1'b0;
        if ((state_q == ST_IDLE) && (cnt_q != '0)) begin
            if (!hold_valid || (hold_addr != chk_addr_q) || (hold_len != chk_len_q)) begin
                err_hit = 1'b1;
            end
        end
        if ((state_q == ST_AW_ACC) && (axi.axi_awaddr[2:0] != 3'b000)) err_hit = 1'b1;
        if ((state_q == ST_AR_ACC) && (axi.axi_araddr[2:0] != 3'b000)) err_hit = 1'b1;
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            chk_wr_q   <= 1'b0;
            chk_addr_q <= '0;
            chk_len_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && (cnt_q == '0)) begin
                chk_wr_q   <= sel_wr;
                chk_addr_q <= sel_wr ? axi.axi_awaddr : axi.axi_araddr;
                chk_len_q  <= sel_wr ? axi.axi_awlen  : axi.axi_arlen;
            end
            if (err_hit) err_q <= 1'b1;
        end
    end

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_axi_resp.sv
// Directed bench for ddr3_axi_resp: burst write/read-back, arbitration,
// wrap and strobes, mid-burst reset and the optional protocol checker.
module tb_ddr3_axi_resp;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 256;
`ifdef DDR3_RESP_CHK_EN
    localparam logic CHK_ON = 1'b1;
`else
    localparam logic CHK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic resp_err;
    int   checks   = 0;
    int   failures = 0;

    logic [255:0] model [16];

    always #5 clk = ~clk;

    ddr3_axi_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ddr3_axi_resp #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_AW    (4),
        .READY_DLY (2),
        .GAP_CYC   (2)
    ) dut (
        .clk_100M (clk),
        .rst      (rst),
        .axi      (bus.slave),
        .resp_err (resp_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pat(input logic [15:0] seed, input int i);
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = {seed, 8'(i), 8'(w)};
        return d;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, 256'(bus.axi_awready), 256'(0));
        chk({tag, "_arready"}, 256'(bus.axi_arready), 256'(0));
        chk({tag, "_wready"},  256'(bus.axi_wready), 256'(0));
        chk({tag, "_wlast"},   256'(bus.axi_wusero_last), 256'(0));
        chk({tag, "_wid"},     256'(bus.axi_wusero_id), 256'(0));
        chk({tag, "_rvalid"},  256'(bus.axi_rvalid), 256'(0));
        chk({tag, "_rlast"},   256'(bus.axi_rlast), 256'(0));
        chk({tag, "_rid"},     256'(bus.axi_rid), 256'(0));
        chk({tag, "_rdata"},   bus.axi_rdata, 256'(0));
        chk({tag, "_resp_err"}, 256'(resp_err), 256'(0));
    endtask

    task automatic aw_req(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id);
        bus.axi_awaddr    = addr;
        bus.axi_awlen     = len;
        bus.axi_awuser_id = id;
        bus.axi_awvalid   = 1'b1;
    endtask

    task automatic ar_req(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id);
        bus.axi_araddr    = addr;
        bus.axi_arlen     = len;
        bus.axi_aruser_id = id;
        bus.axi_arvalid   = 1'b1;
    endtask

    // Counts cycles from now until the ready, then drops that valid
    task automatic wait_ready(input bit is_wr, input int exp_lat, input string tag);
        int n = 0;
        while (!(is_wr ? bus.axi_awready : bus.axi_arready) && n < 64) begin
            cyc();
            n++;
        end
        chk({tag, "_lat"}, 256'(n), 256'(exp_lat));
        chk({tag, "_other_rdy"}, 256'(is_wr ? bus.axi_arready : bus.axi_awready), 256'(0));
        cyc();
        chk({tag, "_rdy_1cyc"}, 256'(is_wr ? bus.axi_awready : bus.axi_arready), 256'(0));
        if (is_wr) bus.axi_awvalid = 1'b0;
        else       bus.axi_arvalid = 1'b0;
    endtask

    task automatic w_beats(input logic [27:0] addr, input int len, input logic [3:0] id,
                           input logic [31:0] strb, input logic [15:0] seed, input string tag);
        logic [255:0] d;
        int idx;
        for (int i = 0; i <= len; i++) begin
            d   = pat(seed, i);
            idx = (int'(addr[6:3]) + i) % 16;
            chk($sformatf("%s_wready%0d", tag, i), 256'(bus.axi_wready), 256'(1));
            chk($sformatf("%s_wlast%0d", tag, i), 256'(bus.axi_wusero_last), 256'(i == len));
            chk($sformatf("%s_wid%0d", tag, i), 256'(bus.axi_wusero_id), 256'(id));
            bus.axi_wdata = d;
            bus.axi_wstrb = strb;
            for (int b = 0; b < 32; b++) if (strb[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
            cyc();
        end
        chk({tag, "_wready_end"}, 256'(bus.axi_wready), 256'(0));
        chk({tag, "_wlast_end"}, 256'(bus.axi_wusero_last), 256'(0));
        bus.axi_wdata = '0;
        bus.axi_wstrb = '0;
    endtask

    task automatic r_beats(input logic [27:0] addr, input int len, input logic [3:0] id, input string tag);
        int idx;
        chk({tag, "_rvalid_lat"}, 256'(bus.axi_rvalid), 256'(0));
        cyc();
        for (int i = 0; i <= len; i++) begin
            idx = (int'(addr[6:3]) + i) % 16;
            chk($sformatf("%s_rvalid%0d", tag, i), 256'(bus.axi_rvalid), 256'(1));
            chk($sformatf("%s_rlast%0d", tag, i), 256'(bus.axi_rlast), 256'(i == len));
            chk($sformatf("%s_rid%0d", tag, i), 256'(bus.axi_rid), 256'(id));
            chk($sformatf("%s_rdata%0d", tag, i), bus.axi_rdata, model[idx]);
            cyc();
        end
        idx = (int'(addr[6:3]) + len) % 16;
        chk({tag, "_rvalid_end"}, 256'(bus.axi_rvalid), 256'(0));
        chk({tag, "_rlast_end"}, 256'(bus.axi_rlast), 256'(0));
        chk({tag, "_rdata_hold"}, bus.axi_rdata, model[idx]);
    endtask

    task automatic write_txn(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id,
                             input logic [31:0] strb, input logic [15:0] seed, input string tag);
        aw_req(addr, len, id);
        wait_ready(1'b1, 3, tag);
        w_beats(addr, int'(len), id, strb, seed, tag);
        cyc();
        cyc();
    endtask

    task automatic read_txn(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id,
                            input string tag);
        ar_req(addr, len, id);
        wait_ready(1'b0, 3, tag);
        r_beats(addr, int'(len), id, tag);
        cyc();
    endtask

    initial begin
        logic [255:0] old_word;
        logic         seen;
        bus.axi_awaddr = '0; bus.axi_awuser_id = '0; bus.axi_awlen = '0; bus.axi_awvalid = 1'b0;
        bus.axi_araddr = '0; bus.axi_aruser_id = '0; bus.axi_arlen = '0; bus.axi_arvalid = 1'b0;
        bus.axi_wdata  = '0; bus.axi_wstrb = '0;
        rst = 1'b1;
        repeat (3) cyc();
        chk_all_zero("reset");
        rst = 1'b0;

        // Full-depth burst then read-back
        write_txn(28'h000_0040, 4'd15, 4'd3, 32'hFFFF_FFFF, 16'h0100, "wr16");
        read_txn(28'h000_0040, 4'd15, 4'd5, "rd16");

        // Wrap past the top of a 16-deep RAM
        write_txn(28'h000_0070, 4'd3, 4'd2, 32'hFFFF_FFFF, 16'h00A0, "wrap_w");
        read_txn(28'h000_0070, 4'd3, 4'd4, "wrap_r");
        read_txn(28'h000_0000, 4'd1, 4'd4, "wrap_low");
        chk("wrap_idx1", bus.axi_rdata, pat(16'h00A0, 3));

        // Low-byte strobe touches bytes 0..3 only
        old_word = model[1];
        write_txn(28'h000_0008, 4'd0, 4'd7, 32'h0000_000F, 16'hFFFF, "strb_w");
        read_txn(28'h000_0008, 4'd0, 4'd7, "strb_r");
        chk("strb_bytes", bus.axi_rdata, {old_word[255:32], 32'hFFFF_0000});

        // Contention alternates write, read, write from reset priority
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        aw_req(28'h000_0040, 4'd1, 4'd1);
        ar_req(28'h000_0040, 4'd1, 4'd2);
        wait_ready(1'b1, 3, "sim_w1");
        w_beats(28'h000_0040, 1, 4'd1, 32'hFFFF_FFFF, 16'h0B00, "sim_w1");
        aw_req(28'h000_0050, 4'd0, 4'd6);
        wait_ready(1'b0, 5, "sim_r1");
        r_beats(28'h000_0040, 1, 4'd2, "sim_r1");
        chk("sim_r1_new_data", bus.axi_rdata, pat(16'h0B00, 1));
        wait_ready(1'b1, 4, "sim_w2");
        w_beats(28'h000_0050, 0, 4'd6, 32'hFFFF_FFFF, 16'h0C00, "sim_w2");
        cyc();
        cyc();

        // Reset during beat 5 of a 16-beat read
        ar_req(28'h000_0040, 4'd15, 4'd9);
        wait_ready(1'b0, 3, "rst_rd");
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rst_rd_rdata%0d", i), bus.axi_rdata, model[(8 + i) % 16]);
            if (i < 4) cyc();
        end
        rst = 1'b1;
        cyc();
        chk_all_zero("rst_mid");
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (bus.axi_rvalid || bus.axi_rlast) seen = 1'b1;
            cyc();
        end
        chk("rst_no_rlast", 256'(seen), 256'(0));
        read_txn(28'h000_0040, 4'd15, 4'd9, "rst_fresh");

        // Valid withdrawn one cycle before ready is never accepted
        aw_req(28'h000_0060, 4'd0, 4'd3);
        cyc();
        cyc();
        bus.axi_awvalid = 1'b0;
        cyc();
        chk("drop_no_rdy", 256'(bus.axi_awready), 256'(0));
        repeat (4) cyc();
        chk("drop_no_rdy_late", 256'(bus.axi_awready), 256'(0));
        chk("drop_resp_err", 256'(resp_err), 256'(CHK_ON));
        write_txn(28'h000_0060, 4'd0, 4'd3, 32'hFFFF_FFFF, 16'h0D00, "drop_retry");
        chk("drop_err_sticky", 256'(resp_err), 256'(CHK_ON));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("err_cleared", 256'(resp_err), 256'(0));

        // Misaligned address is flagged by the checker only
        write_txn(28'h000_0041, 4'd0, 4'd3, 32'hFFFF_FFFF, 16'h0E00, "misalign");
        chk("misalign_err", 256'(resp_err), 256'(CHK_ON));
        read_txn(28'h000_0040, 4'd0, 4'd1, "misalign_rd");
        chk("misalign_err_sticky", 256'(resp_err), 256'(CHK_ON));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("misalign_err_clr", 256'(resp_err), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr3_axi_resp.md
Name: ddr3_axi_resp

Overview:
- Synthesizable AXI-style responder that models the DDR3 IP side of the controller's address/data channels.
- Accepts write/read address requests with awvalid/awready and arvalid/arready.
- Absorbs write bursts by driving wready and wusero_last, and returns read bursts on rvalid, rlast and rid from an internal byte-enabled RAM.
- Used as a stand-in for the DDR3 IP in loopback builds and on the verification bench.

Parameters:
- ADDR_W, 28, AXI address width, in 32-bit word units.
- DATA_W, 256, data beat width (8 x 32 bit).
- MEM_AW, 8, log2 of RAM depth in beats.
- READY_DLY, 2, cycles a valid must be held in IDLE before ready is asserted. Range 0..15.
- GAP_CYC, 2, idle cycles after every burst before the next request is accepted. Range 1..15.

Ports:
- clk_100M  in  1  clock
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- axi_awaddr  in  ADDR_W  write address
- axi_awuser_id  in  4  write ID
- axi_awlen  in  4  write beats minus 1
- axi_awvalid  in  1  write address valid
- axi_awready  out  1  write address ready
- axi_wdata  in  DATA_W  write data
- axi_wstrb  in  DATA_W/8  byte enables
- axi_wready  out  1  beat accepted this cycle
- axi_wusero_id  out  4  ID of the current write burst
- axi_wusero_last  out  1  final write beat
- axi_araddr  in  ADDR_W  read address
- axi_aruser_id  in  4  read ID
- axi_arlen  in  4  read beats minus 1
- axi_arvalid  in  1  read address valid
- axi_arready  out  1  read address ready
- axi_rdata  out  DATA_W  read data
- axi_rid  out  4  read ID
- axi_rlast  out  1  final read beat
- axi_rvalid  out  1  read beat valid; no back-pressure
- resp_err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset: FSM goes to IDLE. Every output is 0: awready, arready, wready, wusero_last, wusero_id, rvalid, rlast, rid, rdata, resp_err. Delay counter, beat counter and priority flag (prio = write) are cleared. RAM contents are preserved.
- A reset asserted mid-burst aborts the burst immediately. No rlast or wusero_last is emitted.
- FSM states, one-hot: IDLE, AW_ACC, AR_ACC, W_BURST, R_BURST, GAP.
- IDLE:
  - The delay counter increments while the selected valid is high. It clears when that valid drops.
  - When the count reaches READY_DLY, go to AW_ACC or AR_ACC.
  - If both valids are high, select per prio. prio toggles after every accepted burst, so accepted requests alternate write/read.
- AW_ACC / AR_ACC:
  - The ready output is high for exactly one cycle. Handshake is guaranteed because the valid is sampled high.
  - Latch addr, len and id.
  - Beat base = addr[MEM_AW+2:3]. Low 3 address bits are ignored.
- W_BURST:
  - wready is high for len+1 consecutive cycles, starting the cycle after the handshake.
  - Each beat writes RAM[(base+beat) mod 2^MEM_AW] with byte enables from wstrb. The index wraps modulo the depth.
  - wusero_id = latched id throughout the burst.
  - wusero_last is high with the final wready.
- R_BURST:
  - RAM has 1-cycle read latency, so the first rvalid comes 2 cycles after the arready cycle.
  - rvalid is high for len+1 consecutive cycles. rlast is high on the final beat. rid = latched id.
  - rdata is held at the last beat value when rvalid is low.
- GAP: wait GAP_CYC cycles, then return to IDLE. A valid arriving during GAP waits, and its delay count starts in IDLE.
- len=0 means a single beat; last asserts on the first beat.
- Write and read never overlap. A read of an address written by an earlier burst returns the new data.

Optional Feature:
- Macro: DDR3_RESP_CHK_EN.
- When defined, resp_err latches to 1 (cleared only by rst) on any of:
  - a valid deasserted while the delay counter is nonzero;
  - address or len changed while valid is held in IDLE;
  - addr[2:0] != 0 at handshake.
- When not defined, resp_err is constant 0 and the checker logic is absent.

Decomposition:
- Package ddr3_axi_pkg holds:
  - state one-hot constants;
  - ID, LEN and strobe width constants;
  - the beats-per-burst helper.
- One sub-module, ddr3_resp_ram: simple dual-port RAM, DATA_W wide, 2^MEM_AW deep, byte-write enable, 1-cycle registered read.

Test Plan:
- Write burst: awaddr=0x000_0040, len=15, id=3 held valid from cycle 0.
  - Expect awready at cycle 3 (READY_DLY=2).
  - Expect 16 wready cycles, wusero_last on the 16th, wusero_id=3.
- Read-back: arvalid at addr 0x40, len=15, id=5.
  - Expect arready one cycle, first rvalid 2 cycles later.
  - Expect 16 beats matching the written data, rlast on beat 16, rid=5.
- Simultaneous: awvalid and arvalid both high after reset.
  - Expect write accepted first, then read, then write again, alternating.
- Wrap and strobes: MEM_AW=4, awaddr=0x70 (base 14), len=3.
  - Expect beats to land in indices 14, 15, 0, 1.
  - A wstrb=0x0000000F beat changes only bytes 0..3.
- Reset mid-read: assert rst at beat 5 of 16.
  - Expect all outputs 0 next cycle, no rlast, FSM in IDLE.
  - Expect a fresh request to be serviced normally afterwards.
- With DDR3_RESP_CHK_EN: drop awvalid one cycle before ready, or use awaddr=0x41.
  - Expect resp_err=1, sticky until rst.
